mult_div_unit: RTL and testbench

Iterative multiply/divide unit for the Minisys CPU execute stage. It produces the 64-bit HI/LO results for mult, multu, div and divu. It drives the decode stage's HI/LO write port (`write_HI_LO`, `ALU_HI`, `ALU_LO`) with a one-cycle write pulse when a result is ready. Radix-2, one bit per cycle, with fixed latency so the pipeline control can stall on `busy` deterministically.

---
 rtl/mult_div_unit.sv | 158 +++++++++++++++
 tb/tb_mult_div_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit for the Minisys execute stage.
// Computes the HI/LO results of mult, multu, div and divu with a fixed
// latency of WIDTH+2 edges from the accepting edge to the write pulse.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             write_HI_LO,
  output logic [WIDTH-1:0] ALU_HI,
  output logic [WIDTH-1:0] ALU_LO,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state, state_next;

  logic [1:0]         op_q;
  logic               sign_a;
  logic               sign_b;
  logic               zero_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   orig_a;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     rem;
  logic [CNT_W-1:0]   count;

  logic               is_signed;
  logic [WIDTH:0]     mult_upper;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] product_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   hi_fix;
  logic [WIDTH-1:0]   lo_fix;

  // Only mult and div (op[0] == 0) treat operands as two's complement.
  assign is_signed = ~op[0];

  assign busy        = (state != IDLE);
  assign write_HI_LO = (state == DONE);
  assign div_by_zero = (state == DONE) && op_q[1] && zero_b;

  // State register; reset drops the unit straight back to IDLE, discarding any operation.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: CALC runs until the counter has seen WIDTH iterations.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (count == CNT_W'(WIDTH)) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One iteration of shift-add multiply or restoring divide, plus sign fix-up of the final result.
  always_comb begin
    mult_upper = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mag_b[0] ? {1'b0, mag_a} : '0);
    div_shift  = {rem[WIDTH-1:0], mag_a[WIDTH-1]};
    div_diff   = div_shift - {1'b0, mag_b};
    div_ge     = (div_shift >= {1'b0, mag_b});

    product_fix = (sign_a ^ sign_b) ? -acc : acc;
    quot_fix    = (sign_a ^ sign_b) ? -mag_a : mag_a;
    rem_fix     = sign_a ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

    hi_fix = product_fix[2*WIDTH-1:WIDTH];
    lo_fix = product_fix[WIDTH-1:0];
    if (op_q[1]) begin
      if (zero_b) begin
        hi_fix = orig_a;
        lo_fix = '1;
      end else begin
        hi_fix = rem_fix;
        lo_fix = quot_fix;
      end
    end
  end

  // Datapath: latch magnitudes on accept, iterate in CALC, publish the corrected result on entering DONE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_q   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      zero_b <= 1'b0;
      mag_a  <= '0;
      mag_b  <= '0;
      orig_a <= '0;
      acc    <= '0;
      rem    <= '0;
      count  <= '0;
      ALU_HI <= '0;
      ALU_LO <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q   <= op;
            sign_a <= is_signed & operand_a[WIDTH-1];
            sign_b <= is_signed & operand_b[WIDTH-1];
            zero_b <= (operand_b == '0);
            mag_a  <= (is_signed && operand_a[WIDTH-1]) ? -operand_a : operand_a;
            mag_b  <= (is_signed && operand_b[WIDTH-1]) ? -operand_b : operand_b;
            orig_a <= operand_a;
            acc    <= '0;
            rem    <= '0;
            count  <= '0;
          end
        end
        CALC: begin
          if (count != CNT_W'(WIDTH)) begin
            if (op_q[1]) begin
              rem   <= div_ge ? div_diff : div_shift;
              mag_a <= {mag_a[WIDTH-2:0], div_ge};
            end else begin
              acc   <= {mult_upper, acc[WIDTH-1:1]};
              mag_b <= mag_b >> 1;
            end
            count <= count + CNT_W'(1);
          end
        end
        FIX: begin
          ALU_HI <= hi_fix;
          ALU_LO <= lo_fix;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit: table of signed/unsigned multiply
// and divide vectors, plus sequences for ignored restarts, back-to-back
// operations and reset during an operation.
module tb_mult_div_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        busy;
  logic        write_HI_LO;
  logic [31:0] ALU_HI;
  logic [31:0] ALU_LO;
  logic        div_by_zero;

  int checks;
  int failures;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vecs[14];

  mult_div_unit #(.WIDTH(32)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .op(op),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .busy(busy),
    .write_HI_LO(write_HI_LO),
    .ALU_HI(ALU_HI),
    .ALU_LO(ALU_LO),
    .div_by_zero(div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // Issues one operation and observes it until busy falls (bounded to 60 edges).
  // repulse_at >= 1 re-asserts start with other operands so it is sampled at that edge.
  task automatic applyStimulus(input logic [1:0] op_in, input logic [31:0] a, input logic [31:0] b,
                               input int repulse_at,
                               output logic [31:0] hi, output logic [31:0] lo, output logic dz,
                               output int latency, output int pulses, output int busy_cycles,
                               output int stray_dz);
    @(negedge clock);
    op        = op_in;
    operand_a = a;
    operand_b = b;
    start     = 1'b1;
    @(posedge clock);
    #1;
    start       = 1'b0;
    operand_a   = 32'hDEAD_BEEF;
    operand_b   = 32'h0000_0000;
    op          = ~op_in;
    hi          = '0;
    lo          = '0;
    dz          = 1'b0;
    latency     = -1;
    pulses      = 0;
    busy_cycles = 0;
    stray_dz    = 0;
    for (int k = 0; k <= 60; k++) begin
      if (busy) busy_cycles++;
      if (div_by_zero && !write_HI_LO) stray_dz++;
      if (write_HI_LO) begin
        pulses++;
        latency = k;
        hi = ALU_HI;
        lo = ALU_LO;
        dz = div_by_zero;
      end
      if (!busy) break;
      if (k == repulse_at - 1) begin
        start     = 1'b1;
        operand_a = 32'd9;
        operand_b = 32'd9;
      end
      if (k == repulse_at) start = 1'b0;
      @(posedge clock);
      #1;
    end
    start = 1'b0;
  endtask

  initial begin
    logic [31:0] hi, lo;
    logic        dz;
    int          latency, pulses, busy_cycles, stray_dz;

    checks    = 0;
    failures  = 0;
    reset     = 1'b0;
    start     = 1'b0;
    op        = 2'b00;
    operand_a = '0;
    operand_b = '0;

    vecs[0]  = '{2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[2]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};
    vecs[3]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[4]  = '{2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0};
    vecs[5]  = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[6]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[7]  = '{2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
    vecs[8]  = '{2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1};
    vecs[9]  = '{2'b01, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0};
    vecs[10] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[11] = '{2'b10, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0002, 1'b0};
    vecs[12] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
    vecs[13] = '{2'b01, 32'h0000_0000, 32'h0000_DEAD, 32'h0000_0000, 32'h0000_0000, 1'b0};

    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_busy", {63'd0, busy}, 64'd0);
    checkOutput("reset_write", {63'd0, write_HI_LO}, 64'd0);
    checkOutput("reset_hi", {32'd0, ALU_HI}, 64'd0);
    checkOutput("reset_lo", {32'd0, ALU_LO}, 64'd0);
    checkOutput("reset_dz", {63'd0, div_by_zero}, 64'd0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, -1, hi, lo, dz, latency, pulses, busy_cycles, stray_dz);
      checkOutput($sformatf("v%0d_hi", i), {32'd0, hi}, {32'd0, vecs[i].hi});
      checkOutput($sformatf("v%0d_lo", i), {32'd0, lo}, {32'd0, vecs[i].lo});
      checkOutput($sformatf("v%0d_dz", i), {63'd0, dz}, {63'd0, vecs[i].dz});
      checkOutput($sformatf("v%0d_latency", i), 64'(latency), 64'd34);
      checkOutput($sformatf("v%0d_pulses", i), 64'(pulses), 64'd1);
      checkOutput($sformatf("v%0d_busy_cycles", i), 64'(busy_cycles), 64'd35);
      checkOutput($sformatf("v%0d_stray_dz", i), 64'(stray_dz), 64'd0);
    end

    applyStimulus(2'b11, 32'd100, 32'd3, 5, hi, lo, dz, latency, pulses, busy_cycles, stray_dz);
    checkOutput("repulse_lo", {32'd0, lo}, 64'd33);
    checkOutput("repulse_hi", {32'd0, hi}, 64'd1);
    checkOutput("repulse_pulses", 64'(pulses), 64'd1);
    checkOutput("repulse_latency", 64'(latency), 64'd34);

    applyStimulus(2'b11, 32'd7, 32'd2, -1, hi, lo, dz, latency, pulses, busy_cycles, stray_dz);
    checkOutput("b2b_latency", 64'(latency), 64'd34);
    checkOutput("b2b_lo", {32'd0, lo}, 64'd3);
    checkOutput("b2b_hi", {32'd0, hi}, 64'd1);

    @(negedge clock);
    op        = 2'b01;
    operand_a = 32'd5;
    operand_b = 32'd5;
    start     = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("midreset_busy", {63'd0, busy}, 64'd0);
    checkOutput("midreset_hi", {32'd0, ALU_HI}, 64'd0);
    checkOutput("midreset_lo", {32'd0, ALU_LO}, 64'd0);
    checkOutput("midreset_write", {63'd0, write_HI_LO}, 64'd0);
    repeat (2) @(negedge clock);
    reset  = 1'b1;
    pulses = 0;
    busy_cycles = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (write_HI_LO) pulses++;
      if (busy) busy_cycles++;
    end
    checkOutput("midreset_no_pulse", 64'(pulses), 64'd0);
    checkOutput("midreset_stays_idle", 64'(busy_cycles), 64'd0);

    applyStimulus(2'b01, 32'd5, 32'd5, -1, hi, lo, dz, latency, pulses, busy_cycles, stray_dz);
    checkOutput("after_reset_lo", {32'd0, lo}, 64'd25);
    checkOutput("after_reset_hi", {32'd0, hi}, 64'd0);
    checkOutput("after_reset_latency", 64'(latency), 64'd34);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
